// File: rtl/current_sense_adc_if.sv
// ---------------------------------------------------------------------------
// current_sense_adc_if
// SPI pin bundle between the current-sense ADC controller and the ADC.
//
// Signals:
//   CS       chip select, active low (driven by the master)
//   CS_CLK   SPI clock, idles high (driven by the master)
//   CS_MISO  serial data from the ADC (driven by the slave)
//
// Modports:
//   master   controller side (drives CS and CS_CLK, reads CS_MISO)
//   slave    ADC side (reads CS and CS_CLK, drives CS_MISO)
// ---------------------------------------------------------------------------
interface current_sense_adc_if;
    logic CS;
    logic CS_CLK;
    logic CS_MISO;

    modport master (
        output CS,
        output CS_CLK,
        input  CS_MISO
    );

    modport slave (
        input  CS,
        input  CS_CLK,
        output CS_MISO
    );
endinterface

// File: rtl/current_sense_adc.sv
// ---------------------------------------------------------------------------
// current_sense_adc
// SPI master for the motor board's 12-bit current-sense ADC. A free-running
// timer requests one 16-bit frame per SAMPLE_PERIOD. Each valid frame is
// offset-corrected into a signed 13-bit current, low-pass filtered by a
// first-order IIR, and checked against an overcurrent limit whose flag is
// latched for the commutation / PWM gating logic.
//
// Ports:
//   CLK           system clock
//   reset_n       asynchronous active-low reset
//   enable        level, high lets periodic sampling run
//   clear_oc      one-cycle pulse, clears the overcurrent latch and count
//   spi           SPI pins (master modport): CS, CS_CLK, CS_MISO
//   current       signed, latest offset-corrected sample
//   current_avg   signed, IIR-filtered current
//   sample_valid  one-cycle pulse when current/current_avg update
//   overcurrent   latched overcurrent flag
//   frame_error   one-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module current_sense_adc #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1600,
    parameter int QUIET         = 8,
    parameter int OFFSET        = 2048,
    parameter int AVG_SHIFT     = 3,
    parameter int OC_LIMIT      = 1800,
    parameter int OC_COUNT      = 4
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear_oc,
    current_sense_adc_if.master  spi,
    output logic signed [12:0]   current,
    output logic signed [12:0]   current_avg,
    output logic                 sample_valid,
    output logic                 overcurrent,
    output logic                 frame_error
);

    localparam int AW   = 13 + AVG_SHIFT;
    localparam int TW   = $clog2(SAMPLE_PERIOD + 1);
    localparam int DMAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [TW-1:0]     TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0]     DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]     QUIET_LAST = DW'(QUIET - 1);
    localparam logic signed [12:0] OFFSET_S  = 13'(OFFSET);
    localparam logic signed [12:0] OC_LIM_S  = 13'(OC_LIMIT);
    localparam logic [3:0]        OC_CNT_P   = 4'(OC_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        PROCESS
    } state_t;

    state_t           state, state_d;
    logic [DW-1:0]    div_cnt, div_d;
    logic [4:0]       bit_cnt, bit_d;
    logic [15:0]      shreg, shreg_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             start_ack;

    logic             miso_s1, miso_s2;
    logic [TW-1:0]    timer;
    logic             pending;

    logic signed [AW-1:0] acc;
    logic                 first_done;
    logic [3:0]           oc_cnt;

    // Datapath values derived from the frame captured in shreg
    logic                 frame_ok;
    logic signed [12:0]   cur_new;
    logic signed [12:0]   cur_abs;
    logic                 over;
    logic signed [AW:0]   cur_wide;
    logic signed [AW:0]   target;
    logic signed [AW:0]   acc_wide;
    logic signed [AW:0]   diff;
    logic signed [AW-1:0] step;
    logic signed [AW-1:0] acc_next;
    logic signed [12:0]   avg_next;
    logic [3:0]           cnt_next;
    logic                 oc_hit;
    logic                 process_ok;

    assign spi.CS     = cs_q;
    assign spi.CS_CLK = sclk_q;

    // MISO is asynchronous to CLK, so bring it in through two flops
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi.CS_MISO;
            miso_s2 <= miso_s1;
        end
    end

    // Free-running sample timer; wraps collapse into a single pending start
    // and are dropped entirely while sampling is disabled
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            if (timer == TIMER_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (!enable) begin
                pending <= 1'b0;
            end else if (timer == TIMER_LAST) begin
                pending <= 1'b1;
            end else if (start_ack) begin
                pending <= 1'b0;
            end
        end
    end

    // FSM state and SPI pin registers; reset forces CS and CS_CLK high at once
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            shreg   <= shreg_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
        end
    end

    // Frame sequencing. CS_CLK spends CLK_DIV cycles low then CLK_DIV high;
    // a bit is captured on the cycle it rises, and the frame ends after the
    // high half of the 16th period so the last bit keeps a full hold time.
    always_comb begin
        state_d   = state;
        div_d     = div_cnt;
        bit_d     = bit_cnt;
        shreg_d   = shreg;
        cs_d      = 1'b1;
        sclk_d    = 1'b1;
        start_ack = 1'b0;

        case (state)
            IDLE: begin
                if (enable && pending) begin
                    state_d   = SETUP;
                    cs_d      = 1'b0;
                    div_d     = '0;
                    start_ack = 1'b1;
                end
            end

            SETUP: begin
                cs_d = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                cs_d   = 1'b0;
                sclk_d = sclk_q;
                if (div_cnt == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shreg_d = {shreg[14:0], miso_s2};
                        bit_d   = bit_cnt + 1'b1;
                    end else if (bit_cnt == 5'd16) begin
                        state_d = HOLD;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (div_cnt == QUIET_LAST) begin
                    state_d = PROCESS;
                    div_d   = '0;
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            PROCESS: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Offset correction, IIR step and overcurrent decision for the captured
    // frame. The IIR difference can span twice the accumulator range, so it
    // is formed one bit wider before the arithmetic shift.
    always_comb begin
        frame_ok = (shreg[15:12] == 4'd0);
        cur_new  = $signed({1'b0, shreg[11:0]}) - OFFSET_S;
        cur_abs  = cur_new[12] ? -cur_new : cur_new;
        over     = (cur_abs > OC_LIM_S);

        cur_wide = $signed({{(AVG_SHIFT + 1){cur_new[12]}}, cur_new});
        target   = cur_wide <<< AVG_SHIFT;
        acc_wide = $signed({acc[AW-1], acc});
        diff     = target - acc_wide;
        step     = AW'(diff >>> AVG_SHIFT);
        acc_next = first_done ? (acc + step) : AW'(target);
        avg_next = $signed(acc_next[AW-1:AVG_SHIFT]);

        if (!over) begin
            cnt_next = 4'd0;
        end else if (oc_cnt >= OC_CNT_P) begin
            cnt_next = OC_CNT_P;
        end else begin
            cnt_next = oc_cnt + 4'd1;
        end
        oc_hit     = over && (cnt_next == OC_CNT_P);
        process_ok = (state == PROCESS) && frame_ok;
    end

    // Output registers. A latching sample beats a simultaneous clear_oc, and
    // a rejected frame leaves the outputs and the OC count untouched.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            current      <= '0;
            current_avg  <= '0;
            acc          <= '0;
            first_done   <= 1'b0;
            oc_cnt       <= '0;
            overcurrent  <= 1'b0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= process_ok;
            frame_error  <= (state == PROCESS) && !frame_ok;

            if (process_ok) begin
                current     <= cur_new;
                current_avg <= avg_next;
                acc         <= acc_next;
                first_done  <= 1'b1;
            end

            if (process_ok) begin
                oc_cnt <= cnt_next;
            end else if (clear_oc) begin
                oc_cnt <= '0;
            end

            if (process_ok && oc_hit) begin
                overcurrent <= 1'b1;
            end else if (clear_oc) begin
                overcurrent <= 1'b0;
            end
        end
    end

endmodule
